// File: rtl/wb_instr_loader_pkg.sv
// Shared definitions for the Wishbone-to-program-SRAM loader: FSM states and
// address decode bit positions.
package wb_instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_ACK
    } state_t;

    localparam int CTRL_CORE_RST = 0;   // CTRL bit holding the core in reset
    localparam int REGION_LSB    = 13;  // region decode compares adr[31:REGION_LSB]
    localparam int CTRL_SEL_BIT  = 12;  // 1 = CTRL register, 0 = SRAM window
    localparam int HALF_BIT      = 2;   // selects 32-bit half of the 64-bit row
    localparam int ROW_LSB       = 3;

endpackage

// File: rtl/wb_instr_loader.sv
// Wishbone slave giving management firmware load/readback access to the 64-bit
// program SRAM pair, plus a CTRL register that holds the core in reset.
module wb_instr_loader
    import wb_instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 9
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [ADDR_W-1:0] instrMgmt_addr,
    output logic [63:0]       instrMgmt_dataOut,
    input  logic [63:0]       instrMgmt_dataIn,
    output logic              instrMgmt_ce,
    output logic              instrMgmt_we,
    output logic [7:0]        instrMgmt_wm,
    output logic              core_rst_o
);

    function automatic logic region_hit(input logic [31:0] adr);
        return adr[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB];
    endfunction

    state_t state;
    logic   half_q;
    logic   req;
    logic   unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i & region_hit(wbs_adr_i);
    assign unused_adr = ^wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state             <= ST_IDLE;
            half_q            <= 1'b0;
            instrMgmt_ce      <= 1'b1;
            instrMgmt_we      <= 1'b1;
            instrMgmt_wm      <= '0;
            instrMgmt_addr    <= '0;
            instrMgmt_dataOut <= '0;
            wbs_ack_o         <= 1'b0;
            wbs_dat_o         <= '0;
            core_rst_o        <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (wbs_adr_i[CTRL_SEL_BIT]) begin
                            if (wbs_we_i) begin
                                if (wbs_sel_i[0])
                                    core_rst_o <= wbs_dat_i[CTRL_CORE_RST];
                            end else begin
                                wbs_dat_o <= {31'b0, core_rst_o};
                            end
                            wbs_ack_o <= 1'b1;
                            state     <= ST_ACK;
                        end else begin
                            instrMgmt_addr <= wbs_adr_i[ADDR_W+ROW_LSB-1:ROW_LSB];
                            instrMgmt_ce   <= 1'b0;
                            instrMgmt_we   <= ~wbs_we_i;
                            half_q         <= wbs_adr_i[HALF_BIT];
                            if (wbs_we_i) begin
                                // Same word on both halves; the mask picks which half lands.
                                instrMgmt_dataOut <= {wbs_dat_i, wbs_dat_i};
                                instrMgmt_wm      <= wbs_adr_i[HALF_BIT] ? {wbs_sel_i, 4'h0}
                                                                         : {4'h0, wbs_sel_i};
                                state             <= ST_WR;
                            end else begin
                                instrMgmt_wm <= '0;
                                state        <= ST_RD;
                            end
                        end
                    end
                end
                ST_WR: begin
                    instrMgmt_ce <= 1'b1;
                    instrMgmt_we <= 1'b1;
                    instrMgmt_wm <= '0;
                    wbs_ack_o    <= 1'b1;
                    state        <= ST_ACK;
                end
                ST_RD: begin
                    instrMgmt_ce <= 1'b1;
                    instrMgmt_we <= 1'b1;
                    state        <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // SRAM data is valid one cycle after the strobe cycle.
                    wbs_dat_o <= half_q ? instrMgmt_dataIn[63:32] : instrMgmt_dataIn[31:0];
                    wbs_ack_o <= 1'b1;
                    state     <= ST_ACK;
                end
                ST_ACK: begin
                    wbs_ack_o <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_instr_loader.sv
// Directed bench for wb_instr_loader: behavioural SRAM, word-level reference
// memory and a per-cycle output checker driven by expected event cycles.
module tb_wb_instr_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [8:0]  m_addr;
    logic [63:0] m_dout, m_din;
    logic        m_ce, m_we;
    logic [7:0]  m_wm;
    logic        core_rst;

    wb_instr_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .instrMgmt_addr(m_addr), .instrMgmt_dataOut(m_dout), .instrMgmt_dataIn(m_din),
        .instrMgmt_ce(m_ce), .instrMgmt_we(m_we), .instrMgmt_wm(m_wm),
        .core_rst_o(core_rst)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural 1rw SRAM with active-low ce/we and per-byte write mask.
    logic [63:0] sram [512];
    logic [63:0] rd_q = '0;
    assign m_din = rd_q;
    always @(posedge clk) begin
        if (!m_ce) begin
            if (!m_we) begin
                for (int b = 0; b < 8; b++)
                    if (m_wm[b]) sram[m_addr][8*b +: 8] <= m_dout[8*b +: 8];
            end else begin
                rd_q <= sram[m_addr];
            end
        end
    end

    // Reference: 32-bit word memory indexed by byte address [11:2].
    logic [31:0] ref_mem [1024];

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    int          exp_ack_cyc = -1, exp_strb_cyc = -1;
    logic        exp_we_n;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_wm;
    logic [63:0] exp_dout;
    int          exp_rst_cyc = 0, exp_dat_cyc = 0;
    logic        exp_rst_old = 1'b1, exp_rst_new = 1'b1;
    logic [31:0] exp_dat_old = '0, exp_dat_new = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", 64'(ack), 64'(cyc_cnt == exp_ack_cyc));
            check("ce_n", 64'(m_ce), 64'(cyc_cnt != exp_strb_cyc));
            if (cyc_cnt == exp_strb_cyc) begin
                check("we_n", 64'(m_we), 64'(exp_we_n));
                check("addr", 64'(m_addr), 64'(exp_addr));
                check("wm", 64'(m_wm), 64'(exp_wm));
                if (!exp_we_n) check("dataOut", m_dout, exp_dout);
            end else begin
                check("we_n_idle", 64'(m_we), 64'd1);
                check("wm_idle", 64'(m_wm), 64'd0);
            end
            check("core_rst", 64'(core_rst),
                  64'((cyc_cnt >= exp_rst_cyc) ? exp_rst_new : exp_rst_old));
            check("dat_o", 64'(dat_o),
                  64'((cyc_cnt >= exp_dat_cyc) ? exp_dat_new : exp_dat_old));
        end
    end

    task automatic sched_rst(input logic v, input int at);
        exp_rst_old = exp_rst_new; exp_rst_new = v; exp_rst_cyc = at;
    endtask

    task automatic sched_dat(input logic [31:0] v, input int at);
        exp_dat_old = exp_dat_new; exp_dat_new = v; exp_dat_cyc = at;
    endtask

    // One WB access; request is presented in cycle n, so the DUT samples it at n+1.
    task automatic wb_access(input logic [31:0] a, input logic w, input logic [3:0] s,
                             input logic [31:0] d, input bit drop_early,
                             output logic [31:0] rdat);
        int  n;
        bit  hit, got;
        logic [31:0] expv;
        @(posedge clk); #1;
        n    = cyc_cnt;
        hit  = (a[31:13] == BASE[31:13]);
        expv = '0;
        if (hit && a[12]) begin
            exp_ack_cyc = n + 1;
            if (w) begin
                if (s[0]) sched_rst(d[0], n + 1);
            end else begin
                sched_dat({31'b0, exp_rst_new}, n + 1);
            end
        end else if (hit) begin
            exp_strb_cyc = n + 1;
            exp_we_n     = ~w;
            exp_addr     = a[11:3];
            if (w) begin
                exp_ack_cyc = n + 2;
                exp_wm      = a[2] ? {s, 4'h0} : {4'h0, s};
                exp_dout    = {d, d};
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_ack_cyc = n + 3;
                exp_wm      = 8'h00;
                sched_dat(ref_mem[a[11:2]], n + 3);
            end
        end
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
        if (drop_early) begin
            @(posedge clk); #1;
            cyc = 1'b0; stb = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) begin got = 1; break; end
        end
        rdat = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check(hit ? "ack_seen" : "no_ack_outside", 64'(got), 64'(hit));
    endtask

    logic [31:0] r;
    int n0;

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ce", 64'(m_ce), 64'd1);
        check("rst_we", 64'(m_we), 64'd1);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_core", 64'(core_rst), 64'd1);
        check("rst_wm", 64'(m_wm), 64'd0);
        check("rst_addr", 64'(m_addr), 64'd0);
        check("rst_dout", m_dout, 64'd0);
        check("rst_dat_o", 64'(dat_o), 64'd0);
        chk_en = 1;

        wb_access(BASE + 32'h1000, 1'b0, 4'hF, 32'h0, 0, r);
        check("ctrl_rd_reset", 64'(r), 64'h1);

        wb_access(BASE + 32'h0C, 1'b1, 4'hF, 32'hDEADBEEF, 0, r);
        wb_access(BASE + 32'h0C, 1'b0, 4'hF, 32'h0, 0, r);
        check("rd_0c", 64'(r), 64'hDEADBEEF);
        wb_access(BASE + 32'h08, 1'b0, 4'hF, 32'h0, 0, r);
        check("rd_08", 64'(r), 64'h0);

        wb_access(BASE + 32'h10, 1'b1, 4'hF, 32'h11223344, 0, r);
        wb_access(BASE + 32'h10, 1'b1, 4'b0010, 32'hAABBCCDD, 0, r);
        wb_access(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 0, r);
        check("byte_wr", 64'(r), 64'h1122CC44);

        wb_access(BASE + 32'h18, 1'b1, 4'h0, 32'hFFFFFFFF, 0, r);
        wb_access(BASE + 32'h18, 1'b0, 4'hF, 32'h0, 0, r);
        check("sel0_wr", 64'(r), 64'h0);

        wb_access(BASE + 32'hFFC, 1'b1, 4'hF, 32'hCAFEF00D, 1, r);
        wb_access(BASE + 32'hFF8, 1'b0, 4'hF, 32'h0, 0, r);
        check("row511_lo", 64'(r), 64'h0);
        wb_access(BASE + 32'hFFC, 1'b0, 4'hF, 32'h0, 1, r);
        check("row511_hi", 64'(r), 64'hCAFEF00D);

        wb_access(BASE + 32'h1000, 1'b1, 4'hF, 32'h0, 0, r);
        check("core_rst_cleared", 64'(core_rst), 64'd0);
        wb_access(BASE + 32'h1000, 1'b0, 4'hF, 32'h0, 0, r);
        check("ctrl_rd_0", 64'(r), 64'h0);

        wb_access(BASE + 32'h2000, 1'b1, 4'hF, 32'h12345678, 0, r);

        // Reset while the read is in RD_WAIT: no ack, registers back to reset values.
        @(posedge clk); #1;
        n0 = cyc_cnt;
        exp_strb_cyc = n0 + 1; exp_we_n = 1'b1; exp_addr = 9'd1; exp_wm = 8'h00;
        exp_ack_cyc  = n0 + 3;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h0C;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        exp_ack_cyc = -1;
        sched_rst(1'b1, n0 + 3);
        sched_dat(32'h0, n0 + 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("core_rst_after_rst", 64'(core_rst), 64'd1);
        repeat (3) @(posedge clk);

        wb_access(BASE + 32'h20, 1'b1, 4'hF, 32'h5A5A1234, 0, r);
        wb_access(BASE + 32'h20, 1'b0, 4'hF, 32'h0, 0, r);
        check("post_rst_rd", 64'(r), 64'h5A5A1234);
        wb_access(BASE + 32'h0C, 1'b0, 4'hF, 32'h0, 0, r);
        check("sram_kept", 64'(r), 64'hDEADBEEF);

        repeat (2) @(posedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
